// File: rtl/stage4_memory_pkg.sv
// Shared types and constants for the memory stage: stream payloads, FSM states
// and the load/store funct3 encodings.
package stage4_memory_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
        logic [31:0] alu_result;
        logic        branch_taken;
        logic [31:0] branch_target;
    } execute_to_memory_t;

    typedef struct packed {
        logic [31:0] decoded_instruction;
        logic [31:0] writeback_value;
        logic        branch_taken;
        logic [31:0] branch_target;
        logic        misaligned;
    } memory_to_writeback_t;

    localparam int ETM_WIDTH = $bits(execute_to_memory_t);
    localparam int MTW_WIDTH = $bits(memory_to_writeback_t);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        OUT
    } mem_state_t;

    // Loads use the I-type immediate, stores the split S-type immediate.
    function automatic logic [31:0] effective_address(input logic [31:0] instruction,
                                                      input logic [31:0] rs1_value,
                                                      input logic        is_store);
        logic [11:0] imm;
        imm = is_store ? {instruction[31:25], instruction[11:7]} : instruction[31:20];
        return rs1_value + {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/stage4_memory_load_store_align.sv
// Combinational lane steering: store strobes/data replication, load lane
// extraction with sign/zero extension, and alignment checking.
module stage4_memory_load_store_align
    import stage4_memory_pkg::*;
#(
    parameter int CHECK_ALIGNMENT = 1
) (
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_check;

    assign w_byte  = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half  = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
    assign w_check = (CHECK_ALIGNMENT != 0);

    always_comb begin
        o_wstrb      = 4'b0000;
        o_wdata      = 32'h0;
        o_load_data  = 32'h0;
        o_misaligned = 1'b0;
        if (i_is_store) begin
            case (i_funct3)
                F3_SB: begin
                    o_wstrb = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_rs2[7:0]}};
                end
                F3_SH: begin
                    o_wstrb      = 4'b0011 << i_addr_lo;
                    o_wdata      = {2{i_rs2[15:0]}};
                    o_misaligned = w_check && i_addr_lo[0];
                end
                F3_SW: begin
                    o_wstrb      = 4'b1111;
                    o_wdata      = i_rs2;
                    o_misaligned = w_check && (i_addr_lo != 2'b00);
                end
                default: o_misaligned = 1'b1;
            endcase
        end else begin
            case (i_funct3)
                F3_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
                F3_LBU: o_load_data = {24'h0, w_byte};
                F3_LH: begin
                    o_load_data  = {{16{w_half[15]}}, w_half};
                    o_misaligned = w_check && i_addr_lo[0];
                end
                F3_LHU: begin
                    o_load_data  = {16'h0, w_half};
                    o_misaligned = w_check && i_addr_lo[0];
                end
                F3_LW: begin
                    o_load_data  = i_rdata;
                    o_misaligned = w_check && (i_addr_lo != 2'b00);
                end
                default: o_misaligned = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/stage4_memory.sv
// Memory pipeline stage: passes ALU results through in one cycle and performs
// blocking, single-outstanding loads/stores on the data-memory port.
module stage4_memory
    import stage4_memory_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = 32,
    parameter int CHECK_ALIGNMENT = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_etm_tvalid,
    output logic                       o_etm_tready,
    input  logic [ETM_WIDTH-1:0]       i_etm_tdata,
    output logic                       o_mtw_tvalid,
    input  logic                       i_mtw_tready,
    output logic [MTW_WIDTH-1:0]       o_mtw_tdata,
    output logic                       o_dmem_req,
    output logic                       o_dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] o_dmem_addr,
    output logic [31:0]                o_dmem_wdata,
    output logic [3:0]                 o_dmem_wstrb,
    input  logic                       i_dmem_ready,
    input  logic                       i_dmem_rvalid,
    input  logic [31:0]                i_dmem_rdata
);

    execute_to_memory_t   w_in;
    memory_to_writeback_t r_out;
    mem_state_t           r_state, w_next;

    logic                       r_valid;
    logic                       r_we;
    logic [2:0]                 r_funct3;
    logic [1:0]                 r_addr_lo;
    logic [DMEM_ADDR_WIDTH-1:0] r_dmem_addr;
    logic [31:0]                r_dmem_wdata;
    logic [3:0]                 r_dmem_wstrb;

    logic        w_is_load, w_is_store, w_is_mem, w_accept;
    logic [31:0] w_addr;
    logic        w_sel_store;
    logic [2:0]  w_sel_funct3;
    logic [1:0]  w_sel_addr_lo;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata, w_load_data;
    logic        w_misaligned;

    assign w_in       = execute_to_memory_t'(i_etm_tdata);
    assign w_is_load  = (w_in.instruction[6:0] == OPC_LOAD);
    assign w_is_store = (w_in.instruction[6:0] == OPC_STORE);
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_addr     = effective_address(w_in.instruction, w_in.rs1_value, w_is_store);

    assign o_etm_tready = (r_state == IDLE) && (!r_valid || i_mtw_tready);
    assign w_accept     = i_etm_tvalid && o_etm_tready;

    // The aligner looks at the incoming instruction while idle and at the
    // captured load parameters while waiting for read data.
    assign w_sel_store   = (r_state == IDLE) && w_is_store;
    assign w_sel_funct3  = (r_state == IDLE) ? w_in.instruction[14:12] : r_funct3;
    assign w_sel_addr_lo = (r_state == IDLE) ? w_addr[1:0] : r_addr_lo;

    stage4_memory_load_store_align #(
        .CHECK_ALIGNMENT(CHECK_ALIGNMENT)
    ) u_align (
        .i_is_store  (w_sel_store),
        .i_funct3    (w_sel_funct3),
        .i_addr_lo   (w_sel_addr_lo),
        .i_rs2       (w_in.rs2_value),
        .i_rdata     (i_dmem_rdata),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata),
        .o_load_data (w_load_data),
        .o_misaligned(w_misaligned)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept && w_is_mem) w_next = w_misaligned ? OUT : REQ;
            REQ:  if (i_dmem_ready)         w_next = r_we ? OUT : RESP;
            RESP: if (i_dmem_rvalid)        w_next = OUT;
            OUT:  if (i_mtw_tready)         w_next = IDLE;
            default:                        w_next = IDLE;
        endcase
    end

    // Output register and dmem request registers; tdata only changes when the
    // output slot is empty or being drained this cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out        <= '0;
            r_valid      <= 1'b0;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= 32'h0;
            r_dmem_wstrb <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_out.decoded_instruction <= w_in.instruction;
                        r_out.branch_taken        <= w_in.branch_taken;
                        r_out.branch_target       <= w_in.branch_target;
                        r_out.misaligned          <= 1'b0;
                        r_out.writeback_value     <= w_in.alu_result;
                        r_valid                   <= 1'b1;
                        if (w_is_mem) begin
                            r_out.writeback_value <= 32'h0;
                            if (w_misaligned) begin
                                r_out.misaligned <= 1'b1;
                            end else begin
                                r_valid      <= 1'b0;
                                r_we         <= w_is_store;
                                r_funct3     <= w_in.instruction[14:12];
                                r_addr_lo    <= w_addr[1:0];
                                r_dmem_addr  <= {w_addr[DMEM_ADDR_WIDTH-1:2], 2'b00};
                                r_dmem_wdata <= w_wdata;
                                r_dmem_wstrb <= w_wstrb;
                            end
                        end
                    end else if (i_mtw_tready) begin
                        r_valid <= 1'b0;
                    end
                end
                REQ:  if (i_dmem_ready && r_we) r_valid <= 1'b1;
                RESP: if (i_dmem_rvalid) begin
                    r_out.writeback_value <= w_load_data;
                    r_valid               <= 1'b1;
                end
                OUT:  if (i_mtw_tready) r_valid <= 1'b0;
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign o_mtw_tvalid = r_valid;
    assign o_mtw_tdata  = r_out;
    assign o_dmem_req   = (r_state == REQ);
    assign o_dmem_we    = r_we;
    assign o_dmem_addr  = r_dmem_addr;
    assign o_dmem_wdata = r_dmem_wdata;
    assign o_dmem_wstrb = r_dmem_wstrb;

endmodule

// File: tb/tb_stage4_memory.sv
// Directed plus randomized bench for stage4_memory against a byte-level memory
// model and an arithmetic reference for addresses, lanes and extension.
module tb_stage4_memory;
    import stage4_memory_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 etmValid = 1'b0;
    logic                 etmReady;
    logic [ETM_WIDTH-1:0] etmData = '0;
    logic                 mtwValid;
    logic                 mtwReady = 1'b1;
    logic [MTW_WIDTH-1:0] mtwData;
    logic                 dmemReq, dmemWe;
    logic [31:0]          dmemAddr, dmemWdata;
    logic [3:0]           dmemWstrb;
    logic                 dmemReady = 1'b0;
    logic                 dmemRvalid = 1'b0;
    logic [31:0]          dmemRdata = 32'h0;

    memory_to_writeback_t outData;
    assign outData = memory_to_writeback_t'(mtwData);

    int checks = 0;
    int errors = 0;
    logic [31:0] memWords [int unsigned];

    stage4_memory #(.DMEM_ADDR_WIDTH(32), .CHECK_ALIGNMENT(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_etm_tvalid(etmValid), .o_etm_tready(etmReady), .i_etm_tdata(etmData),
        .o_mtw_tvalid(mtwValid), .i_mtw_tready(mtwReady), .o_mtw_tdata(mtwData),
        .o_dmem_req(dmemReq), .o_dmem_we(dmemWe), .o_dmem_addr(dmemAddr),
        .o_dmem_wdata(dmemWdata), .o_dmem_wstrb(dmemWstrb),
        .i_dmem_ready(dmemReady), .i_dmem_rvalid(dmemRvalid), .i_dmem_rdata(dmemRdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] memRead(input int unsigned idx);
        if (memWords.exists(idx)) return memWords[idx];
        return (idx * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] mkAlu(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd5, 7'h13};
    endfunction

    function automatic logic [31:0] mkLoad(input logic [2:0] f3, input logic [11:0] imm);
        return {imm, 5'd2, f3, 5'd3, 7'h03};
    endfunction

    function automatic logic [31:0] mkStore(input logic [2:0] f3, input logic [11:0] imm);
        return {imm[11:5], 5'd4, 5'd2, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [ETM_WIDTH-1:0] pack(input logic [31:0] instr, rs1, rs2, alu,
                                                  input logic bt, input logic [31:0] btgt);
        execute_to_memory_t d;
        d.instruction   = instr;
        d.rs1_value     = rs1;
        d.rs2_value     = rs2;
        d.alu_result    = alu;
        d.branch_taken  = bt;
        d.branch_target = btgt;
        return d;
    endfunction

    // Drives one instruction and follows it to the output, emulating dmem with
    // the given ready/rvalid delays and holding downstream off for 'stall' cycles.
    task automatic applyStimulus(input logic [31:0] instr, rs1, rs2, alu, input logic bt,
                                 input logic [31:0] btgt, input int readyDelay,
                                 input int rvalidDelay, input int stall);
        bit isLoad, isStore, isSigned, mis;
        int size, off, imm;
        logic [11:0] imm12;
        logic [31:0] ea, expWb, expWdata, word;
        logic [3:0] expStrb;
        longint v;
        int unsigned idx;

        isLoad  = (instr[6:0] == 7'h03);
        isStore = (instr[6:0] == 7'h23);
        imm12   = isStore ? {instr[31:25], instr[11:7]} : instr[31:20];
        imm     = $signed(imm12);
        ea      = rs1 + 32'(imm);
        off     = int'(ea % 4);
        idx     = ea / 4;
        case (instr[14:12])
            3'd0:    size = 1;
            3'd1:    size = 2;
            3'd2:    size = 4;
            3'd4:    size = isStore ? 0 : 1;
            3'd5:    size = isStore ? 0 : 2;
            default: size = 0;
        endcase
        isSigned = (instr[14:12] < 3'd4);
        mis      = (size == 0) || ((ea % size) != 0);
        expWb    = alu;
        expStrb  = 4'(((1 << size) - 1) << off);
        expWdata = 32'h0;
        for (int i = 0; i < 4; i++)
            if (size != 0) expWdata[8*i +: 8] = rs2[8*(i % size) +: 8];
        if (isLoad || isStore) expWb = 32'h0;

        etmValid = 1'b1;
        etmData  = pack(instr, rs1, rs2, alu, bt, btgt);
        mtwReady = (stall == 0);
        checkOutput("accept_tready", etmReady, 1);
        @(negedge clk);
        etmValid = 1'b0;
        etmData  = '0;

        if ((isLoad || isStore) && !mis) begin
            checkOutput("req_assert", dmemReq, 1);
            checkOutput("req_we", dmemWe, isStore);
            checkOutput("in_tready_busy", etmReady, 0);
            for (int k = 0; k <= readyDelay; k++) begin
                if (k > 0) @(negedge clk);
                checkOutput("req_held", dmemReq, 1);
                checkOutput("req_addr", dmemAddr, ea & 32'hFFFF_FFFC);
                checkOutput("out_empty_req", mtwValid, 0);
                if (isStore) begin
                    checkOutput("req_wstrb", dmemWstrb, expStrb);
                    checkOutput("req_wdata", dmemWdata, expWdata);
                end
            end
            dmemReady = 1'b1;
            @(negedge clk);
            dmemReady = 1'b0;
            checkOutput("req_drop", dmemReq, 0);
            if (isLoad) begin
                for (int k = 0; k < rvalidDelay; k++) begin
                    checkOutput("wait_rvalid", mtwValid, 0);
                    @(negedge clk);
                end
                checkOutput("wait_rvalid_last", mtwValid, 0);
                word       = memRead(idx);
                dmemRvalid = 1'b1;
                dmemRdata  = word;
                @(negedge clk);
                dmemRvalid = 1'b0;
                dmemRdata  = $urandom;
                v = (longint'({32'h0, word}) >> (8 * off)) % (longint'(1) << (8 * size));
                if (isSigned && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                    v = v - (longint'(1) << (8 * size));
                expWb = 32'(v);
            end else begin
                word = memRead(idx);
                for (int b = 0; b < size; b++) word[8*(off+b) +: 8] = rs2[8*b +: 8];
                memWords[idx] = word;
            end
        end else begin
            checkOutput("no_req", dmemReq, 0);
        end

        checkOutput("out_valid", mtwValid, 1);
        checkOutput("out_wb", outData.writeback_value, expWb);
        checkOutput("out_misaligned", outData.misaligned, 32'((isLoad || isStore) && mis));
        checkOutput("out_instr", outData.decoded_instruction, instr);
        if (!isLoad && !isStore) begin
            checkOutput("out_btaken", outData.branch_taken, bt);
            checkOutput("out_btarget", outData.branch_target, btgt);
        end
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            checkOutput("stall_valid", mtwValid, 1);
            checkOutput("stall_wb", outData.writeback_value, expWb);
            checkOutput("stall_in_tready", etmReady, 0);
        end
        mtwReady = 1'b1;
        @(negedge clk);
        checkOutput("drain_valid", mtwValid, 0);
        checkOutput("drain_in_tready", etmReady, 1);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [11:0] rimm;
        logic [31:0] rs1;
        int kind;

        // Reset state
        #2 rst_n = 1'b0;
        #2;
        checkOutput("rst_tvalid", mtwValid, 0);
        checkOutput("rst_req", dmemReq, 0);
        checkOutput("rst_we", dmemWe, 0);
        checkOutput("rst_wstrb", dmemWstrb, 0);
        checkOutput("rst_addr", dmemAddr, 0);
        checkOutput("rst_wdata", dmemWdata, 0);
        checkOutput("rst_in_tready", etmReady, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dmemRvalid = 1'b1;
        dmemRdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        dmemRvalid = 1'b0;
        checkOutput("idle_rvalid_ignored", mtwValid, 0);

        $display("[TB] ADDI passthrough");
        applyStimulus(mkAlu(12'd5), 32'h0, 32'h0, 32'h5, 1'b1, 32'h0000_0400, 0, 0, 0);

        $display("[TB] SB with ready delay");
        applyStimulus(mkStore(F3_SB, 12'd3), 32'h1000, 32'hAB, 32'h0, 1'b0, 32'h0, 3, 0, 0);

        $display("[TB] LB/LBU with rvalid delay");
        memWords[32'h2000 / 4] = 32'h0080_0000;
        applyStimulus(mkLoad(F3_LB, 12'd2), 32'h2000, 32'h0, 32'h0, 1'b0, 32'h0, 0, 4, 0);
        applyStimulus(mkLoad(F3_LBU, 12'd2), 32'h2000, 32'h0, 32'h0, 1'b0, 32'h0, 1, 4, 1);

        $display("[TB] misaligned LW and unknown funct3");
        applyStimulus(mkLoad(F3_LW, 12'd0), 32'h2001, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 0);
        applyStimulus(mkStore(3'd5, 12'd0), 32'h2000, 32'h55, 32'h0, 1'b0, 32'h0, 0, 0, 0);

        $display("[TB] back-to-back ADDIs with downstream stall");
        etmValid = 1'b1;
        etmData  = pack(mkAlu(12'd1), 32'h0, 32'h0, 32'h111, 1'b0, 32'h0);
        mtwReady = 1'b0;
        checkOutput("b2b_first_tready", etmReady, 1);
        @(negedge clk);
        etmData = pack(mkAlu(12'd2), 32'h0, 32'h0, 32'h222, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            checkOutput("b2b_hold_valid", mtwValid, 1);
            checkOutput("b2b_hold_wb", outData.writeback_value, 32'h111);
            checkOutput("b2b_hold_tready", etmReady, 0);
            if (k == 0) @(negedge clk);
        end
        mtwReady = 1'b1;
        #1 checkOutput("b2b_release_tready", etmReady, 1);
        @(negedge clk);
        etmValid = 1'b0;
        checkOutput("b2b_second_valid", mtwValid, 1);
        checkOutput("b2b_second_wb", outData.writeback_value, 32'h222);
        @(negedge clk);
        checkOutput("b2b_no_dup", mtwValid, 0);

        $display("[TB] reset during REQ and RESP");
        etmValid = 1'b1;
        etmData  = pack(mkStore(F3_SW, 12'd0), 32'h2400, 32'h1234_5678, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        etmValid = 1'b0;
        checkOutput("rreq_req_before", dmemReq, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rreq_req_async", dmemReq, 0);
        checkOutput("rreq_we_async", dmemWe, 0);
        checkOutput("rreq_addr_async", dmemAddr, 0);
        checkOutput("rreq_wstrb_async", dmemWstrb, 0);
        @(negedge clk);
        rst_n = 1'b1;
        etmValid = 1'b1;
        etmData  = pack(mkLoad(F3_LW, 12'd0), 32'h2000, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        etmValid  = 1'b0;
        dmemReady = 1'b1;
        @(negedge clk);
        dmemReady = 1'b0;
        checkOutput("rresp_busy", etmReady, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rresp_tvalid_async", mtwValid, 0);
        checkOutput("rresp_req_async", dmemReq, 0);
        checkOutput("rresp_idle_async", etmReady, 1);
        @(negedge clk);
        rst_n      = 1'b1;
        dmemRvalid = 1'b1;
        dmemRdata  = 32'hCAFE_F00D;
        @(negedge clk);
        dmemRvalid = 1'b0;
        checkOutput("rresp_late_rvalid", mtwValid, 0);
        applyStimulus(mkAlu(12'd9), 32'h0, 32'h0, 32'h0000_0009, 1'b0, 32'h0, 0, 0, 0);

        $display("[TB] randomized sequence");
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            f3   = 3'($urandom_range(0, 7));
            rimm = 12'($urandom_range(0, 31)) - 12'd16;
            rs1  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : 32'h3000 + $urandom_range(0, 255);
            case (kind)
                0: applyStimulus(mkAlu(rimm), rs1, $urandom, $urandom, 1'($urandom),
                                 $urandom, 0, 0, $urandom_range(0, 2));
                1: applyStimulus(mkLoad(f3, rimm), rs1, $urandom, $urandom, 1'b0, 32'h0,
                                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
                default: applyStimulus(mkStore(f3, rimm), rs1, $urandom, $urandom, 1'b0, 32'h0,
                                 $urandom_range(0, 3), 0, $urandom_range(0, 2));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
